pipe_hazard_ctrl: RTL and testbench

Central hazard and stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the stall and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, applies EX-stage branch/jump redirects, and sequences multi-cycle mul/div operations through a start/done handshake. Cache misses cause a global freeze. The block also maintains stall and redirect performance counters.

---
 rtl/pipe_hazard_ctrl_if.sv | 49 ++++
 rtl/pipe_hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status inputs and register control outputs.
// The master side belongs to the pipeline; the slave side is the hazard controller.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W  = 32,
   parameter int RCNT_W = 16
);
   logic              icache_stall_i;
   logic              dcache_stall_i;
   logic [4:0]        id_rs1_addr_i;
   logic [4:0]        id_rs2_addr_i;
   logic              id_uses_rs1_i;
   logic              id_uses_rs2_i;
   logic              ex_memread_i;
   logic [4:0]        ex_rd_addr_i;
   logic              ex_redirect_i;
   logic              ex_muldiv_i;
   logic              md_done_i;

   logic              pc_stall_o;
   logic              if_id_stall_o;
   logic              id_ex_stall_o;
   logic              ex_mem_stall_o;
   logic              mem_wb_stall_o;
   logic              if_id_flush_o;
   logic              id_ex_flush_o;
   logic              ex_mem_flush_o;
   logic              pc_redirect_o;
   logic              md_start_o;
   logic [CNT_W-1:0]  stall_cycles_o;
   logic [RCNT_W-1:0] redirect_cnt_o;

   modport master (
      output icache_stall_i, dcache_stall_i, id_rs1_addr_i, id_rs2_addr_i,
             id_uses_rs1_i, id_uses_rs2_i, ex_memread_i, ex_rd_addr_i,
             ex_redirect_i, ex_muldiv_i, md_done_i,
      input  pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
             mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
             pc_redirect_o, md_start_o, stall_cycles_o, redirect_cnt_o
   );

   modport slave (
      input  icache_stall_i, dcache_stall_i, id_rs1_addr_i, id_rs2_addr_i,
             id_uses_rs1_i, id_uses_rs2_i, ex_memread_i, ex_rd_addr_i,
             ex_redirect_i, ex_muldiv_i, md_done_i,
      output pc_stall_o, if_id_stall_o, id_ex_stall_o, ex_mem_stall_o,
             mem_wb_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o,
             pc_redirect_o, md_start_o, stall_cycles_o, redirect_cnt_o
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirects,
// multi-cycle mul/div handshake, cache freeze, plus saturating perf counters.
module pipe_hazard_ctrl #(
   parameter int CNT_W  = 32,
   parameter int RCNT_W = 16
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      MD_DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic freeze;
   logic load_use;
   logic rs1_hit;
   logic rs2_hit;

   logic pc_stall;
   logic if_id_stall;
   logic id_ex_stall;
   logic ex_mem_stall;
   logic mem_wb_stall;
   logic if_id_flush;
   logic id_ex_flush;
   logic ex_mem_flush;
   logic pc_redirect;
   logic md_start;

   logic [CNT_W-1:0]  stall_cnt;
   logic [RCNT_W-1:0] redirect_cnt;

   function automatic logic [CNT_W-1:0] sat_inc_stall(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [RCNT_W-1:0] sat_inc_redir(input logic [RCNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign freeze  = bus.icache_stall_i | bus.dcache_stall_i;
   assign rs1_hit = bus.id_uses_rs1_i & (bus.id_rs1_addr_i == bus.ex_rd_addr_i);
   assign rs2_hit = bus.id_uses_rs2_i & (bus.id_rs2_addr_i == bus.ex_rd_addr_i);
   assign load_use = bus.ex_memread_i & (bus.ex_rd_addr_i != 5'd0) & (rs1_hit | rs2_hit);

   always_comb begin
      next_state   = state;
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      pc_redirect  = 1'b0;
      md_start     = 1'b0;
      // Everything stays quiet while reset is held; the register block returns to RUN.
      if (rst_n) begin
         unique case (state)
            RUN: begin
               if (freeze) begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_stall = 1'b1;
                  mem_wb_stall = 1'b1;
               end else if (bus.ex_redirect_i) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
                  pc_redirect = 1'b1;
               end else if (bus.ex_muldiv_i) begin
                  md_start     = 1'b1;
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_flush = 1'b1;
                  next_state   = MD_WAIT;
               end else if (load_use) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
               end
            end
            MD_WAIT: begin
               // Done with no freeze: release everything so the result lands in EX/MEM.
               if (bus.md_done_i && !freeze) begin
                  next_state = RUN;
               end else begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_stall = 1'b1;
                  if (freeze) begin
                     ex_mem_stall = 1'b1;
                     mem_wb_stall = 1'b1;
                  end else begin
                     ex_mem_flush = 1'b1;
                  end
                  if (bus.md_done_i) next_state = MD_DONE;
               end
            end
            MD_DONE: begin
               if (freeze) begin
                  pc_stall     = 1'b1;
                  if_id_stall  = 1'b1;
                  id_ex_stall  = 1'b1;
                  ex_mem_stall = 1'b1;
                  mem_wb_stall = 1'b1;
               end else begin
                  next_state = RUN;
               end
            end
            default: next_state = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= RUN;
         stall_cnt    <= '0;
         redirect_cnt <= '0;
      end else begin
         state <= next_state;
         if (pc_stall)    stall_cnt    <= sat_inc_stall(stall_cnt);
         if (pc_redirect) redirect_cnt <= sat_inc_redir(redirect_cnt);
      end
   end

   assign bus.pc_stall_o     = pc_stall;
   assign bus.if_id_stall_o  = if_id_stall;
   assign bus.id_ex_stall_o  = id_ex_stall;
   assign bus.ex_mem_stall_o = ex_mem_stall;
   assign bus.mem_wb_stall_o = mem_wb_stall;
   assign bus.if_id_flush_o  = if_id_flush;
   assign bus.id_ex_flush_o  = id_ex_flush;
   assign bus.ex_mem_flush_o = ex_mem_flush;
   assign bus.pc_redirect_o  = pc_redirect;
   assign bus.md_start_o     = md_start;
   assign bus.stall_cycles_o = stall_cnt;
   assign bus.redirect_cnt_o = redirect_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle vectors with expected control outputs,
// checked through a scoreboard queue against a small counter model.
module tb_pipe_hazard_ctrl;

   localparam int CNT_W  = 32;
   localparam int RCNT_W = 2;

   // Output bit order: pc_s, if_id_s, id_ex_s, ex_mem_s, mem_wb_s, if_id_f, id_ex_f, ex_mem_f, redir, start
   localparam logic [9:0] O_NONE  = 10'h000;
   localparam logic [9:0] O_FRZ   = 10'h3E0;
   localparam logic [9:0] O_LU    = 10'h308;
   localparam logic [9:0] O_REDIR = 10'h01A;
   localparam logic [9:0] O_MDST  = 10'h385;
   localparam logic [9:0] O_MDW   = 10'h384;

   typedef struct {
      bit         rst;
      bit         ic;
      bit         dc;
      logic [4:0] rs1;
      logic [4:0] rs2;
      bit         u1;
      bit         u2;
      bit         mr;
      logic [4:0] rd;
      bit         redir;
      bit         md;
      bit         done;
      logic [9:0] exp;
   } vec_t;

   typedef struct {
      int                id;
      logic [9:0]        outs;
      logic [CNT_W-1:0]  sc;
      logic [RCNT_W-1:0] rc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W), .RCNT_W(RCNT_W)) ifc ();

   pipe_hazard_ctrl #(.CNT_W(CNT_W), .RCNT_W(RCNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   logic [9:0] act;
   assign act = {ifc.pc_stall_o, ifc.if_id_stall_o, ifc.id_ex_stall_o, ifc.ex_mem_stall_o,
                 ifc.mem_wb_stall_o, ifc.if_id_flush_o, ifc.id_ex_flush_o, ifc.ex_mem_flush_o,
                 ifc.pc_redirect_o, ifc.md_start_o};

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   vec_t vecs[$];
   logic [CNT_W-1:0]  m_stall = '0;
   logic [RCNT_W-1:0] m_redir = '0;
   int step_id = 0;

   function automatic vec_t mk(bit rst, bit ic, bit dc, logic [4:0] rs1, logic [4:0] rs2,
                               bit u1, bit u2, bit mr, logic [4:0] rd, bit redir,
                               bit md, bit done, logic [9:0] exp);
      vec_t v;
      v.rst = rst; v.ic = ic; v.dc = dc; v.rs1 = rs1; v.rs2 = rs2;
      v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd; v.redir = redir;
      v.md = md; v.done = done; v.exp = exp;
      return v;
   endfunction

   function automatic vec_t idle(bit done, logic [9:0] exp);
      return mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, done, exp);
   endfunction

   // Drive one cycle of stimulus, push its expectation, compare at the falling edge.
   task automatic step(input vec_t v);
      exp_t e;
      exp_t got;
      rst_n              = ~v.rst;
      ifc.icache_stall_i = v.ic;
      ifc.dcache_stall_i = v.dc;
      ifc.id_rs1_addr_i  = v.rs1;
      ifc.id_rs2_addr_i  = v.rs2;
      ifc.id_uses_rs1_i  = v.u1;
      ifc.id_uses_rs2_i  = v.u2;
      ifc.ex_memread_i   = v.mr;
      ifc.ex_rd_addr_i   = v.rd;
      ifc.ex_redirect_i  = v.redir;
      ifc.ex_muldiv_i    = v.md;
      ifc.md_done_i      = v.done;
      e.id   = step_id;
      e.outs = v.exp;
      e.sc   = m_stall;
      e.rc   = m_redir;
      sb.push_back(e);
      if (v.rst) begin
         m_stall = '0;
         m_redir = '0;
      end else begin
         if (v.exp[9]) m_stall = m_stall + 1'b1;
         if (v.exp[1] && m_redir != {RCNT_W{1'b1}}) m_redir = m_redir + 1'b1;
      end
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (act !== got.outs) begin
         errors++;
         $display("FAIL outs[%0d] got %h want %h", got.id, act, got.outs);
      end
      checks++;
      if (ifc.stall_cycles_o !== got.sc) begin
         errors++;
         $display("FAIL stall_cycles[%0d] got %0d want %0d", got.id, ifc.stall_cycles_o, got.sc);
      end
      checks++;
      if (ifc.redirect_cnt_o !== got.rc) begin
         errors++;
         $display("FAIL redirect_cnt[%0d] got %0d want %0d", got.id, ifc.redirect_cnt_o, got.rc);
      end
      step_id++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      ifc.icache_stall_i = 0; ifc.dcache_stall_i = 0;
      ifc.id_rs1_addr_i = 0;  ifc.id_rs2_addr_i = 0;
      ifc.id_uses_rs1_i = 0;  ifc.id_uses_rs2_i = 0;
      ifc.ex_memread_i = 0;   ifc.ex_rd_addr_i = 0;
      ifc.ex_redirect_i = 0;  ifc.ex_muldiv_i = 0;
      ifc.md_done_i = 0;
      repeat (2) @(posedge clk);
      #1;

      //            rst ic dc rs1   rs2   u1 u2 mr rd    rdr md dn exp
      vecs.push_back(mk(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, O_NONE));
      vecs.push_back(idle(0, O_NONE));
      vecs.push_back(mk(0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, O_LU));
      vecs.push_back(idle(0, O_NONE));
      vecs.push_back(mk(0, 0, 0, 5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, O_NONE));
      vecs.push_back(mk(0, 0, 0, 5'd5, 5'd0, 0, 0, 1, 5'd5, 0, 0, 0, O_NONE));
      vecs.push_back(mk(0, 0, 0, 5'd3, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, O_LU));
      vecs.push_back(mk(0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, O_REDIR));
      vecs.push_back(mk(0, 1, 0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, O_FRZ));
      vecs.push_back(mk(0, 0, 0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, 0, O_MDST));
      vecs.push_back(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_MDW));
      vecs.push_back(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_NONE));
      vecs.push_back(idle(1, O_NONE));
      vecs.push_back(idle(0, O_NONE));
      vecs.push_back(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, O_REDIR));
      vecs.push_back(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, O_REDIR));
      vecs.push_back(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, O_REDIR));
      vecs.push_back(idle(0, O_NONE));

      foreach (vecs[i]) step(vecs[i]);

      // Mul/div: start at cycle 0, done at cycle 4, then a load-use proves RUN.
      step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_MDST));
      for (int c = 1; c < 4; c++) step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_MDW));
      step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_NONE));
      step(mk(0, 0, 0, 5'd9, 5'd0, 1, 0, 1, 5'd9, 0, 0, 1, O_LU));
      step(idle(1, O_NONE));

      // Mul/div under a D-cache miss (cycles 2-6) with done at cycle 3.
      step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_MDST));
      step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_MDW));
      step(mk(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_FRZ));
      for (int c = 3; c <= 6; c++) step(mk(0, 0, 1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_FRZ));
      step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, O_NONE));
      step(idle(1, O_NONE));

      // Reset while waiting on a mul/div abandons it and clears both counters.
      step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_MDST));
      step(mk(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_MDW));
      step(mk(1, 0, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, O_NONE));
      step(idle(0, O_NONE));
      step(mk(0, 0, 0, 5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 0, 0, O_LU));
      step(idle(0, O_NONE));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
